// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling constants and word-length decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [3:0] OSM16_MID = 4'd7;
    localparam logic [3:0] OSM13_MID = 4'd6;
    localparam int unsigned OSM16 = 16;
    localparam int unsigned OSM13 = 13;

    // Word-length select to data-bit count: 00 -> 5 ... 11 -> 8
    function automatic logic [3:0] wls_to_len(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input. Resets to 1 so an idle-high line
// never looks like a falling edge while coming out of reset.
module uart_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversamples the synchronized line on baud ticks, mid-samples each bit,
// checks parity and stop bits, and emits one word per frame with error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       OSM_SEL,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       STB,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       rx_busy
);

    localparam logic [3:0] Last16 = 4'(OSM16 - 1);
    localparam logic [3:0] Last13 = 4'(OSM13 - 1);

    logic rx_s;

    uart_sync #(
        .Stages(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (rx_i),
        .q_o  (rx_s)
    );

    rx_state_t  state_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       stop2_q;      // first of two stop bits already sampled
    logic       par_err_q;
    logic       frm_err_q;
    logic       zero_q;       // every sample of this frame so far was low
    logic       wait_high_q;  // after a break, line must go high before re-arming

    // Frame configuration captured at the start edge
    logic       osm_sel_q;
    logic [3:0] len_q;
    logic       pen_q;
    logic       eps_q;
    logic       stb_q;

    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       parity_err_q;
    logic       frame_err_q;
    logic       break_det_q;

    logic [3:0] mid_cnt;
    logic [3:0] last_cnt;
    logic       at_sample;
    logic       exp_parity;

    // Per-frame tick targets and the expected parity of the received word
    always_comb begin
        mid_cnt    = osm_sel_q ? OSM13_MID : OSM16_MID;
        last_cnt   = osm_sel_q ? Last13 : Last16;
        at_sample  = (cnt_q == last_cnt);
        exp_parity = (^shift_q) ^ ~eps_q;
    end

    // Receive FSM with registered outputs; advances only on baud ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            stop2_q      <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            zero_q       <= 1'b0;
            wait_high_q  <= 1'b0;
            osm_sel_q    <= 1'b0;
            len_q        <= 4'd5;
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            stb_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (baud_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (wait_high_q) begin
                            if (rx_s) wait_high_q <= 1'b0;
                        end else if (!rx_s) begin
                            osm_sel_q <= OSM_SEL;
                            len_q     <= wls_to_len(WLS);
                            pen_q     <= PEN;
                            eps_q     <= EPS;
                            stb_q     <= STB;
                            cnt_q     <= '0;
                            state_q   <= START;
                        end
                    end
                    START: begin
                        if (cnt_q == mid_cnt) begin
                            if (rx_s) begin
                                state_q <= IDLE;  // glitch, not a real start bit
                            end else begin
                                cnt_q     <= '0;
                                bit_q     <= '0;
                                shift_q   <= '0;
                                stop2_q   <= 1'b0;
                                par_err_q <= 1'b0;
                                frm_err_q <= 1'b0;
                                zero_q    <= 1'b1;
                                state_q   <= DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    DATA: begin
                        if (at_sample) begin
                            cnt_q          <= '0;
                            shift_q[bit_q] <= rx_s;
                            if (rx_s) zero_q <= 1'b0;
                            if ({1'b0, bit_q} == len_q - 4'd1) begin
                                state_q <= pen_q ? PARITY : STOP;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    PARITY: begin
                        if (at_sample) begin
                            cnt_q <= '0;
                            if (rx_s != exp_parity) par_err_q <= 1'b1;
                            if (rx_s) zero_q <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    STOP: begin
                        if (at_sample) begin
                            cnt_q <= '0;
                            if (stb_q && !stop2_q) begin
                                stop2_q <= 1'b1;
                                if (!rx_s) frm_err_q <= 1'b1;
                                if (rx_s) zero_q <= 1'b0;
                            end else begin
                                rx_valid_q   <= 1'b1;
                                rx_data_q    <= shift_q;
                                parity_err_q <= par_err_q;
                                frame_err_q  <= frm_err_q | ~rx_s;
                                break_det_q  <= zero_q & ~rx_s;
                                wait_high_q  <= zero_q & ~rx_s;
                                state_q      <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign rx_busy    = (state_q != IDLE);

endmodule
